// File: rtl/lcd_id_rd.sv
// LCD panel ID reader: releases the RGB pads, samples the strap bits several
// times, and decodes a stable strap code into a panel ID with bounded retries.
module lcd_id_rd #(
    parameter int SETTLE_CYC = 50000,
    parameter int SAMPLE_GAP = 1000,
    parameter int SAMPLE_NUM = 4,
    parameter int MAX_TRY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] lcd_rgb_in,
    input  logic        rescan,
    output logic        lcd_rgb_oe,
    output logic [15:0] lcd_id,
    output logic        id_valid,
    output logic        id_err,
    output logic        busy
);
    localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_GAP) ? SETTLE_CYC : SAMPLE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        SETTLE = 3'd0,
        SAMPLE = 3'd1,
        GAP    = 3'd2,
        DECODE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Returns {error, id}; unlisted strap codes are reported as errors.
    function automatic logic [16:0] decode_id(input logic [2:0] code);
        case (code)
            3'b000:  decode_id = {1'b0, 16'h4342};
            3'b001:  decode_id = {1'b0, 16'h7084};
            3'b010:  decode_id = {1'b0, 16'h7016};
            3'b100:  decode_id = {1'b0, 16'h4384};
            3'b101:  decode_id = {1'b0, 16'h1018};
            default: decode_id = {1'b1, 16'h0000};
        endcase
    endfunction

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [3:0]         smp_r, smp_s;
    logic [2:0]         try_r, try_s;
    logic [2:0]         ref_r, ref_s;
    logic               bad_r, bad_s;
    logic [2:0]         sync1_r, sync2_r;
    logic [15:0]        id_r, id_s;
    logic               valid_r, valid_s;
    logic               err_r, err_s;
    logic               busy_r, busy_s;
    logic               oe_r, oe_s;
    logic               run_r;
    logic [2:0]         strap_s;
    logic [16:0]        dec_s;
    logic               unused_pads_s;

    assign strap_s       = {lcd_rgb_in[23], lcd_rgb_in[15], lcd_rgb_in[7]};
    // Only the MSB of each colour carries a strap; the other pad bits are ignored.
    assign unused_pads_s = ^{lcd_rgb_in[22:16], lcd_rgb_in[14:8], lcd_rgb_in[6:0]};
    assign dec_s         = decode_id(ref_r);

    assign lcd_rgb_oe = oe_r;
    assign lcd_id     = id_r;
    assign id_valid   = valid_r;
    assign id_err     = err_r;
    assign busy       = busy_r;

    // State, counters, strap synchroniser and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= SETTLE;
            cnt_r   <= {CNT_W{1'b0}};
            smp_r   <= 4'd0;
            try_r   <= 3'd0;
            ref_r   <= 3'd0;
            bad_r   <= 1'b0;
            sync1_r <= 3'd0;
            sync2_r <= 3'd0;
            id_r    <= 16'h0000;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            oe_r    <= 1'b0;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            smp_r   <= smp_s;
            try_r   <= try_s;
            ref_r   <= ref_s;
            bad_r   <= bad_s;
            sync1_r <= strap_s;
            sync2_r <= sync1_r;
            id_r    <= id_s;
            valid_r <= valid_s;
            err_r   <= err_s;
            busy_r  <= busy_s;
            oe_r    <= oe_s;
            run_r   <= 1'b1;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        smp_s   = smp_r;
        try_s   = try_r;
        ref_s   = ref_r;
        bad_s   = bad_r;
        id_s    = id_r;
        valid_s = valid_r;
        err_s   = err_r;
        busy_s  = busy_r;
        oe_s    = oe_r;
        if (!run_r) begin
            // The cycle right after reset only arms the sequence so t=0 starts cleanly.
            state_s = SETTLE;
            cnt_s   = {CNT_W{1'b0}};
            smp_s   = 4'd0;
            try_s   = 3'd0;
            bad_s   = 1'b0;
            busy_s  = 1'b1;
        end else begin
            case (state_r)
                SETTLE: begin
                    if (cnt_r == CNT_W'(SETTLE_CYC - 1)) begin
                        state_s = SAMPLE;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (smp_r == 4'd0) begin
                        ref_s = sync2_r;
                    end else if (sync2_r != ref_r) begin
                        bad_s = 1'b1;
                    end else begin
                        bad_s = bad_r;
                    end
                    smp_s = smp_r + 4'd1;
                    if (smp_r == 4'(SAMPLE_NUM - 1)) begin
                        state_s = DECODE;
                    end else begin
                        state_s = GAP;
                    end
                end
                GAP: begin
                    if (cnt_r == CNT_W'(SAMPLE_GAP - 1)) begin
                        state_s = SAMPLE;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                DECODE: begin
                    if (bad_r) begin
                        if (try_r < 3'(MAX_TRY - 1)) begin
                            state_s = SETTLE;
                            try_s   = try_r + 3'd1;
                            cnt_s   = {CNT_W{1'b0}};
                            smp_s   = 4'd0;
                            bad_s   = 1'b0;
                        end else begin
                            state_s = DONE;
                            id_s    = 16'h0000;
                            valid_s = 1'b0;
                            err_s   = 1'b1;
                            busy_s  = 1'b0;
                            oe_s    = 1'b0;
                        end
                    end else begin
                        state_s = DONE;
                        id_s    = dec_s[15:0];
                        err_s   = dec_s[16];
                        valid_s = ~dec_s[16];
                        oe_s    = ~dec_s[16];
                        busy_s  = 1'b0;
                    end
                end
                DONE: begin
                    if (rescan) begin
                        state_s = SETTLE;
                        cnt_s   = {CNT_W{1'b0}};
                        smp_s   = 4'd0;
                        try_s   = 3'd0;
                        bad_s   = 1'b0;
                        id_s    = 16'h0000;
                        valid_s = 1'b0;
                        err_s   = 1'b0;
                        oe_s    = 1'b0;
                        busy_s  = 1'b1;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: begin
                    state_s = SETTLE;
                    cnt_s   = {CNT_W{1'b0}};
                    smp_s   = 4'd0;
                    try_s   = 3'd0;
                    bad_s   = 1'b0;
                    busy_s  = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/lcd_id_rd.md
LCD_ID_RD -- requirements
Module: lcd_id_rd

Interface
REQ-001 Parameter SETTLE_CYC, default 50000, cycles the bus stays released before the first sample (1 ms at 50 MHz).
REQ-002 Parameter SAMPLE_GAP, default 1000, idle cycles between consecutive samples.
REQ-003 Parameter SAMPLE_NUM, default 4, number of samples that must agree (range 2..15).
REQ-004 Parameter MAX_TRY, default 3, total read attempts before declaring error (range 1..7).
REQ-005 clk  input  1  system clock, 50 MHz.
REQ-006 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-007 lcd_rgb_in  input  24  panel RGB data pads read back while released; {R[7:0],G[7:0],B[7:0]}.
REQ-008 rescan  input  1  single-cycle request to re-read the panel ID.
REQ-009 lcd_rgb_oe  output  1  1 = controller may drive RGB pads; 0 = pads released.
REQ-010 lcd_id  output  16  decoded panel ID.
REQ-011 id_valid  output  1  lcd_id holds a recognised ID.
REQ-012 id_err  output  1  read finished without a usable ID.
REQ-013 busy  output  1  read sequence in progress.

Function
REQ-014 Strap bits SHALL be M2=lcd_rgb_in[23], M1=lcd_rgb_in[15], M0=lcd_rgb_in[7], passed through a 2-flop synchroniser before use.
REQ-015 Decode of {M2,M1,M0}: 000->16'h4342, 001->16'h7084, 010->16'h7016, 100->16'h4384, 101->16'h1018; any other code SHALL give lcd_id=16'h0000, id_err=1, id_valid=0.
REQ-016 States SHALL be SETTLE, SAMPLE, GAP, DECODE, DONE; one state per cycle except SETTLE and GAP, which hold for their counts.
REQ-017 SETTLE: lcd_rgb_oe=0, busy=1, counts SETTLE_CYC cycles, then goes to SAMPLE.
REQ-018 SAMPLE (1 cycle): first sample of an attempt is stored as reference; each later sample is compared to it; any mismatch flags the attempt bad.
REQ-019 GAP: SAMPLE_GAP cycles between samples; after the SAMPLE_NUM-th sample the FSM goes to DECODE, not GAP.
REQ-020 With t=0 the first cycle in SETTLE, sample k (k=0..SAMPLE_NUM-1) SHALL occur in cycle SETTLE_CYC+k*(SAMPLE_GAP+1); DECODE in the cycle after the last sample; outputs update at the end of DECODE.
REQ-021 DECODE with a bad attempt and attempts-used < MAX_TRY: increment attempt counter and return to SETTLE with counters cleared.
REQ-022 DECODE with a bad attempt and attempts-used = MAX_TRY: enter DONE with lcd_id=0, id_err=1, id_valid=0.
REQ-023 DECODE with a good attempt: enter DONE with lcd_id/id_valid/id_err per REQ-015.
REQ-024 DONE: busy=0; lcd_rgb_oe=1 only if id_valid=1, else 0; outputs held until rescan or reset.
REQ-025 rescan in DONE: next cycle SETTLE, attempt counter cleared, id_valid=0, id_err=0, lcd_id=0, lcd_rgb_oe=0, busy=1.
REQ-026 rescan while busy=1 SHALL be ignored (no restart, no queueing).
REQ-027 Counters SHALL be wide enough for parameter maxima; no wrap-around within any state.

Reset
REQ-028 While rst_n=0 at a clk edge: lcd_rgb_oe=0, lcd_id=0, id_valid=0, id_err=0, busy=0, all counters and synchronisers cleared.
REQ-029 First cycle after rst_n returns high SHALL be SETTLE (t=0) with busy=1.
REQ-030 Reset asserted mid-sequence or in DONE SHALL abort immediately and restart per REQ-028/029.

Verification (SETTLE_CYC=4, SAMPLE_GAP=2, SAMPLE_NUM=3, MAX_TRY=3)
REQ-031 Straps 001 stable -> samples at t=4,7,10, DECODE t=11; at t=12 lcd_id=16'h7084, id_valid=1, id_err=0, lcd_rgb_oe=1, busy=0.
REQ-032 Straps 011 stable -> at t=12 lcd_id=0, id_err=1, id_valid=0, lcd_rgb_oe=0.
REQ-033 Straps 000 but M0 toggles before the t=7 sample on every attempt -> three attempts (DECODE at t=11,23,35); at t=36 id_err=1, lcd_id=0.
REQ-034 Mismatch on first attempt only, straps 101 afterwards -> second attempt DECODE at t=23; at t=24 lcd_id=16'h1018, id_valid=1.
REQ-035 In DONE with 16'h7084, straps changed to 100, rescan pulse -> id_valid=0 next cycle, 13 cycles later lcd_id=16'h4384; rescan pulsed at t=6 of that sequence has no effect.
REQ-036 rst_n low at t=8 for one cycle -> all outputs 0 that cycle, then sequence restarts at t=0 with busy=1.
